// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared types and constants for the mem_master bus initiator
package mem_master_pkg;

  localparam int MEM_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    I_CAP,
    D_RD,
    D_CAP,
    D_WR,
    ACK
  } mm_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_LOAD,
    GNT_STORE
  } mm_grant_t;

  // First state of the access path that a grant starts.
  function automatic mm_state_t grant_to_state(input mm_grant_t g);
    mm_state_t s;
    case (g)
      GNT_FETCH: s = I_RD;
      GNT_LOAD:  s = D_RD;
      GNT_STORE: s = D_WR;
      default:   s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - core-side request/ack and memory command signals of mem_master
interface mem_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;
  logic              ld_req;
  logic              st_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] st_data;
  logic              ls_ack;
  logic [DATA_W-1:0] ld_data;
  logic              mem_i_read;
  logic              mem_i_push;
  logic              mem_d_read;
  logic              mem_d_push;
  logic              mem_d_write;
  logic [ADDR_W-1:0] mem_i_addr;
  logic [ADDR_W-1:0] mem_d_addr;
  logic [DATA_W-1:0] mem_i_bus;

  modport master (
    input  fetch_req, fetch_addr, ld_req, st_req, ls_addr, st_data, mem_i_bus,
    output fetch_ack, fetch_data, ls_ack, ld_data,
    output mem_i_read, mem_i_push, mem_d_read, mem_d_push, mem_d_write,
    output mem_i_addr, mem_d_addr
  );

  modport slave (
    output fetch_req, fetch_addr, ld_req, st_req, ls_addr, st_data, mem_i_bus,
    input  fetch_ack, fetch_data, ls_ack, ld_data,
    input  mem_i_read, mem_i_push, mem_d_read, mem_d_push, mem_d_write,
    input  mem_i_addr, mem_d_addr
  );

endinterface

// File: rtl/mem_master_arb.sv
// rtl/mem_master_arb.sv - fetch vs load/store request picker
// MEM_MASTER_RR_EN selects round-robin between fetch and data; otherwise data has priority.
module mem_master_arb
  import mem_master_pkg::*;
(
  input  logic      fetch_req_i,
  input  logic      ld_req_i,
  input  logic      st_req_i,
`ifdef MEM_MASTER_RR_EN
  input  logic      last_grant_i,
`endif
  output mm_grant_t grant_o
);

  logic      data_req;
  mm_grant_t data_gnt;

  always_comb begin
    data_req = ld_req_i | st_req_i;
    // A load and store together is a core error: the load wins, the store is dropped.
    data_gnt = ld_req_i ? GNT_LOAD : GNT_STORE;
    grant_o  = GNT_NONE;
    if (data_req && fetch_req_i) begin
`ifdef MEM_MASTER_RR_EN
      grant_o = last_grant_i ? data_gnt : GNT_FETCH;
`else
      grant_o = data_gnt;
`endif
    end else if (data_req) begin
      grant_o = data_gnt;
    end else if (fetch_req_i) begin
      grant_o = GNT_FETCH;
    end
  end

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - serializes core fetch/load/store into one memory command per cycle
// MEM_MASTER_RR_EN enables round-robin fetch/data arbitration with a last_grant register.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_master_if.master      bus,
  inout  wire  [DATA_W-1:0] mem_d_bus
);

  mm_state_t         state_q, state_d;
  mm_grant_t         gnt_q, gnt_d;
  mm_grant_t         grant;
  logic              accept;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              i_read_q, i_read_d;
  logic              i_push_q, i_push_d;
  logic              d_read_q, d_read_d;
  logic              d_push_q, d_push_d;
  logic              d_write_q, d_write_d;
  logic              drive_q, drive_d;
  logic              fetch_ack_q, fetch_ack_d;
  logic              ls_ack_q, ls_ack_d;
`ifdef MEM_MASTER_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  mem_master_arb u_arb (
    .fetch_req_i  (bus.fetch_req),
    .ld_req_i     (bus.ld_req),
    .st_req_i     (bus.st_req),
`ifdef MEM_MASTER_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_o      (grant)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    i_addr_d     = i_addr_q;
    d_addr_d     = d_addr_q;
    st_data_d    = st_data_q;
    fetch_data_d = fetch_data_q;
    ld_data_d    = ld_data_q;
`ifdef MEM_MASTER_RR_EN
    last_grant_d = last_grant_q;
`endif
    accept = ((state_q == IDLE) || (state_q == ACK)) && (grant != GNT_NONE);

    case (state_q)
      IDLE, ACK: state_d = accept ? grant_to_state(grant) : IDLE;
      I_RD:      state_d = I_CAP;
      I_CAP:     state_d = ACK;
      D_RD:      state_d = D_CAP;
      D_CAP:     state_d = ACK;
      D_WR:      state_d = ACK;
      default:   state_d = IDLE;
    endcase

    if (accept) begin
      gnt_d = grant;
      if (grant == GNT_FETCH) begin
        i_addr_d = bus.fetch_addr;
      end else begin
        d_addr_d = bus.ls_addr;
      end
      if (grant == GNT_STORE) begin
        st_data_d = bus.st_data;
      end
`ifdef MEM_MASTER_RR_EN
      // Records which side won, so a contested pair next time goes the other way.
      last_grant_d = (grant == GNT_FETCH);
`endif
    end

    if (state_q == I_CAP) fetch_data_d = bus.mem_i_bus;
    if (state_q == D_CAP) ld_data_d    = mem_d_bus;

    // Controls are decoded from the next state so every memory-facing pin is a flop.
    i_read_d    = (state_d == I_RD);
    i_push_d    = (state_d == I_CAP);
    d_read_d    = (state_d == D_RD);
    d_push_d    = (state_d == D_CAP);
    d_write_d   = (state_d == D_WR);
    drive_d     = (state_d == D_WR);
    fetch_ack_d = (state_d == ACK) && (gnt_d == GNT_FETCH);
    ls_ack_d    = (state_d == ACK) && ((gnt_d == GNT_LOAD) || (gnt_d == GNT_STORE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_NONE;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      st_data_q    <= '0;
      fetch_data_q <= '0;
      ld_data_q    <= '0;
      i_read_q     <= 1'b0;
      i_push_q     <= 1'b0;
      d_read_q     <= 1'b0;
      d_push_q     <= 1'b0;
      d_write_q    <= 1'b0;
      drive_q      <= 1'b0;
      fetch_ack_q  <= 1'b0;
      ls_ack_q     <= 1'b0;
`ifdef MEM_MASTER_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      i_addr_q     <= i_addr_d;
      d_addr_q     <= d_addr_d;
      st_data_q    <= st_data_d;
      fetch_data_q <= fetch_data_d;
      ld_data_q    <= ld_data_d;
      i_read_q     <= i_read_d;
      i_push_q     <= i_push_d;
      d_read_q     <= d_read_d;
      d_push_q     <= d_push_d;
      d_write_q    <= d_write_d;
      drive_q      <= drive_d;
      fetch_ack_q  <= fetch_ack_d;
      ls_ack_q     <= ls_ack_d;
`ifdef MEM_MASTER_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.fetch_ack   = fetch_ack_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.ls_ack      = ls_ack_q;
  assign bus.ld_data     = ld_data_q;
  assign bus.mem_i_read  = i_read_q;
  assign bus.mem_i_push  = i_push_q;
  assign bus.mem_d_read  = d_read_q;
  assign bus.mem_d_push  = d_push_q;
  assign bus.mem_d_write = d_write_q;
  assign bus.mem_i_addr  = i_addr_q;
  assign bus.mem_d_addr  = d_addr_q;

  assign mem_d_bus = drive_q ? st_data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed bench for mem_master with a small memory model
// Contested-grant expectations follow MEM_MASTER_RR_EN.
module tb_mem_master;
  import mem_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_master_if mif ();
  wire [15:0] mem_d_bus;

  mem_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (mif),
    .mem_d_bus (mem_d_bus)
  );

  logic [15:0] mem [MEM_WORDS];
  logic [15:0] i_lat = 16'h0;
  logic [15:0] d_lat = 16'h0;
  logic        preloaded = 1'b0;

  always @(posedge clk) begin
    if (!rst_n && !preloaded) begin
      for (int k = 0; k < MEM_WORDS; k++) mem[k] <= 16'h0;
      mem[8'h02] <= 16'h0017;
      mem[8'h10] <= 16'hFF10;
      mem[8'h40] <= 16'h1111;
      mem[8'h50] <= 16'h5A5A;
      preloaded  <= 1'b1;
    end
    if (mif.mem_i_read)  i_lat <= mem[mif.mem_i_addr[7:0]];
    if (mif.mem_d_read)  d_lat <= mem[mif.mem_d_addr[7:0]];
    if (mif.mem_d_write) mem[mif.mem_d_addr[7:0]] <= mem_d_bus;
  end

  assign mif.mem_i_bus = i_lat;
  assign mem_d_bus = mif.mem_d_push ? d_lat : 16'hzzzz;

  int n_iread = 0, n_ipush = 0, n_dwrite = 0, n_drive = 0, n_lsack = 0;
  int viol_cmd = 0, viol_bus = 0;

  always @(negedge clk) begin
    n_iread  <= n_iread  + (mif.mem_i_read  ? 1 : 0);
    n_ipush  <= n_ipush  + (mif.mem_i_push  ? 1 : 0);
    n_dwrite <= n_dwrite + (mif.mem_d_write ? 1 : 0);
    n_drive  <= n_drive  + (dut.drive_q     ? 1 : 0);
    n_lsack  <= n_lsack  + (mif.ls_ack      ? 1 : 0);
    if ($countones({mif.mem_i_read, mif.mem_d_read, mif.mem_d_write}) > 1) viol_cmd <= viol_cmd + 1;
    if (dut.drive_q && mif.mem_d_push) viol_bus <= viol_bus + 1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_fetch(input logic [15:0] a, output int lat, output logic [15:0] d);
    @(negedge clk); #1;
    mif.fetch_addr = a;
    mif.fetch_req  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!mif.fetch_ack && lat < 20);
    d = mif.fetch_data;
    mif.fetch_req = 1'b0;
  endtask

  task automatic run_ls(input logic ld, input logic st, input logic [15:0] a,
                        input logic [15:0] wd, output int lat, output logic [15:0] d);
    @(negedge clk); #1;
    mif.ls_addr = a;
    mif.st_data = wd;
    mif.ld_req  = ld;
    mif.st_req  = st;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!mif.ls_ack && lat < 20);
    d = mif.ld_data;
    mif.ld_req = 1'b0;
    mif.st_req = 1'b0;
  endtask

  task automatic run_pair(output int t_f, output int t_l, output logic [15:0] fd, output logic [15:0] ld);
    @(negedge clk); #1;
    mif.fetch_addr = 16'h0002;
    mif.ls_addr    = 16'h0010;
    mif.fetch_req  = 1'b1;
    mif.ld_req     = 1'b1;
    t_f = 0; t_l = 0; fd = 16'h0; ld = 16'h0;
    for (int c = 1; c <= 20 && (mif.fetch_req || mif.ld_req); c++) begin
      @(negedge clk); #1;
      if (mif.fetch_ack) begin t_f = c; fd = mif.fetch_data; mif.fetch_req = 1'b0; end
      if (mif.ls_ack)    begin t_l = c; ld = mif.ld_data;    mif.ld_req    = 1'b0; end
    end
    mif.fetch_req = 1'b0;
    mif.ld_req    = 1'b0;
  endtask

  int          lat, t_f, t_l, s0, s1, s2, s3;
  logic [15:0] d, fd, ld;

  initial begin
    rst_n = 1'b0;
    mif.fetch_req = 1'b0; mif.fetch_addr = '0;
    mif.ld_req = 1'b0; mif.st_req = 1'b0; mif.ls_addr = '0; mif.st_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {27'd0, mif.mem_i_read, mif.mem_i_push, mif.mem_d_read, mif.mem_d_push, mif.mem_d_write}, 32'h0);
    chk("rst_acks", {30'd0, mif.fetch_ack, mif.ls_ack}, 32'h0);
    chk("rst_data", {mif.fetch_data, mif.ld_data}, 32'h0);
    chk("rst_addr", {mif.mem_i_addr, mif.mem_d_addr}, 32'h0);
    chk("rst_drive", {31'd0, dut.drive_q}, 32'h0);
    rst_n = 1'b1;

    s0 = n_iread; s1 = n_ipush;
    run_fetch(16'h0010, lat, d);
    chk("fetch_lat", lat, 3);
    chk("fetch_data", {16'h0, d}, 32'hFF10);
    chk("fetch_iaddr", {16'h0, mif.mem_i_addr}, 32'h0010);
    chk("fetch_iread_cycles", n_iread - s0, 1);
    chk("fetch_ipush_cycles", n_ipush - s1, 1);

    s0 = n_drive; s1 = n_dwrite;
    run_ls(1'b0, 1'b1, 16'h0040, 16'hBEEF, lat, d);
    chk("store_lat", lat, 2);
    chk("store_drive_cycles", n_drive - s0, 1);
    chk("store_write_cycles", n_dwrite - s1, 1);
    chk("store_mem", {16'h0, mem[8'h40]}, 32'hBEEF);
    chk("store_daddr", {16'h0, mif.mem_d_addr}, 32'h0040);

    s0 = n_drive;
    run_ls(1'b1, 1'b0, 16'h0040, 16'h0000, lat, d);
    chk("load_lat", lat, 3);
    chk("load_data", {16'h0, d}, 32'hBEEF);
    chk("load_no_drive", n_drive - s0, 0);
    chk("fetch_data_hold", {16'h0, mif.fetch_data}, 32'hFF10);

    run_pair(t_f, t_l, fd, ld);
`ifdef MEM_MASTER_RR_EN
    chk("pair1_fetch_t", t_f, 3);
    chk("pair1_load_t", t_l, 6);
`else
    chk("pair1_load_t", t_l, 3);
    chk("pair1_fetch_t", t_f, 6);
`endif
    chk("pair1_fd", {16'h0, fd}, 32'h0017);
    chk("pair1_ld", {16'h0, ld}, 32'hFF10);

    run_fetch(16'h0002, lat, d);
    chk("fetch2_lat", lat, 3);
    chk("fetch2_data", {16'h0, d}, 32'h0017);

    run_pair(t_f, t_l, fd, ld);
    chk("pair2_load_t", t_l, 3);
    chk("pair2_fetch_t", t_f, 6);

    s0 = n_dwrite;
    run_ls(1'b1, 1'b1, 16'h0040, 16'h5555, lat, d);
    chk("ldst_lat", lat, 3);
    chk("ldst_data", {16'h0, d}, 32'hBEEF);
    chk("ldst_no_write", n_dwrite - s0, 0);
    chk("ldst_mem", {16'h0, mem[8'h40]}, 32'hBEEF);

    @(negedge clk); #1;
    s0 = n_lsack; s1 = n_dwrite;
    mif.ls_addr = 16'h0050; mif.st_data = 16'h1234; mif.st_req = 1'b1;
    @(posedge clk); #3;
    chk("rstmid_in_dwr", {31'd0, dut.drive_q}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_write", {31'd0, mif.mem_d_write}, 32'h0);
    chk("rstmid_drive", {31'd0, dut.drive_q}, 32'h0);
    chk("rstmid_data", {mif.fetch_data, mif.ld_data}, 32'h0);
    chk("rstmid_addr", {mif.mem_i_addr, mif.mem_d_addr}, 32'h0);
    mif.st_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rstmid_no_ack", n_lsack - s0, 0);
    chk("rstmid_no_write", n_dwrite - s1, 0);
    chk("rstmid_mem", {16'h0, mem[8'h50]}, 32'h5A5A);
    run_ls(1'b1, 1'b0, 16'h0050, 16'h0000, lat, d);
    chk("rstmid_reload", {16'h0, d}, 32'h5A5A);

    @(negedge clk); #1;
    chk("one_cmd_per_cycle", viol_cmd, 0);
    chk("no_drive_with_push", viol_bus, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
